pong_wb_ctrl: RTL and testbench

//  Wishbone control/status slave for the pong game on the Caravel user area; replaces pin/LA-only control.

---
 rtl/pong_pkg.sv | 24 ++
 rtl/pong_wb_ctrl_clk_en_divider.sv | 25 ++
 rtl/pong_wb_ctrl.sv | 145 ++++++++++++++
 tb/tb_pong_wb_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared register map, CTRL bit positions and bus helpers for the pong Wishbone control slave.
package pong_pkg;

    localparam int MAX_PLAYERS = 8;

    localparam logic [7:0] REG_CTRL   = 8'h00;
    localparam logic [7:0] REG_CLKDIV = 8'h04;
    localparam logic [7:0] REG_SCORE  = 8'h08;
    localparam logic [7:0] REG_IRQ    = 8'h0C;

    localparam int CTRL_SOFT_RST = 0;
    localparam int CTRL_DIFF_OVR = 1;
    localparam int CTRL_DIFF_LSB = 4;

    // Expands the four byte-lane selects into a 32-bit write mask.
    function automatic logic [31:0] lane_mask(input logic [3:0] sel);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) begin
            m[8*b +: 8] = {8{sel[b]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/pong_wb_ctrl_clk_en_divider.sv
// Programmable clock-enable divider: counts 0..div and pulses ce on the terminal count.
module clk_en_divider import pong_pkg::*; #(
    parameter int DIV_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DIV_WIDTH-1:0] div,
    input  logic                 load,
    output logic                 ce
);

    logic [DIV_WIDTH-1:0] count;

    // The >= compare keeps the counter bounded if div shrinks below the current count.
    always_ff @(posedge clk) begin
        if (rst || load || count >= div) begin
            count <= '0;
        end else begin
            count <= count + DIV_WIDTH'(1);
        end
    end

    assign ce = !rst && (count == div);

endmodule

// File: rtl/pong_wb_ctrl.sv
// Wishbone control/status slave for the pong core: soft reset, difficulty, game clock enable, scores.
// Define PONG_WB_IRQ_EN to build the score-change interrupt (IRQ register at 0x0C and irq_o).
module pong_wb_ctrl import pong_pkg::*; #(
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
    parameter int          NUM_PLAYERS = 2,
    parameter int          DIV_WIDTH   = 8,
    parameter int          DEFAULT_DIV = 2
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic                     wbs_stb_i,
    input  logic                     wbs_cyc_i,
    input  logic                     wbs_we_i,
    input  logic [3:0]               wbs_sel_i,
    input  logic [31:0]              wbs_dat_i,
    input  logic [31:0]              wbs_adr_i,
    output logic                     wbs_ack_o,
    output logic [31:0]              wbs_dat_o,
    input  logic                     la_rst_i,
    input  logic [3:0]               pad_difficulty_i,
    input  logic [4*NUM_PLAYERS-1:0] score_i,
    output logic                     game_rst_o,
    output logic [3:0]               difficulty_o,
    output logic                     game_ce_o,
    output logic                     irq_o
);

    logic                 in_window;
    logic                 req;
    logic                 wr;
    logic [7:0]           offset;
    logic [31:0]          wmask;
    logic [31:0]          rd_data;
    logic                 soft_reset;
    logic                 diff_override;
    logic [3:0]           diff_val;
    logic [DIV_WIDTH-1:0] clkdiv;
    logic [DIV_WIDTH-1:0] clkdiv_wr_val;
    logic                 div_load;
    logic                 unused_adr;

    assign in_window = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign req       = wbs_stb_i && wbs_cyc_i && in_window && !wbs_ack_o;
    assign wr        = req && wbs_we_i;
    assign offset    = {wbs_adr_i[7:2], 2'b00};
    assign wmask     = lane_mask(wbs_sel_i);
    assign unused_adr = &{1'b0, wbs_adr_i[1:0]};

    assign clkdiv_wr_val = DIV_WIDTH'((32'(clkdiv) & ~wmask) | (wbs_dat_i & wmask));
    assign div_load      = wr && (offset == REG_CLKDIV) && (|wmask[DIV_WIDTH-1:0]);

    assign difficulty_o = diff_override ? diff_val : pad_difficulty_i;

`ifdef PONG_WB_IRQ_EN
    logic [4*NUM_PLAYERS-1:0] score_q;
    logic [NUM_PLAYERS-1:0]   pending;
    logic [NUM_PLAYERS-1:0]   irq_mask;
    logic [NUM_PLAYERS-1:0]   changed;
    logic [NUM_PLAYERS-1:0]   w1c;
    logic [7:0]               pending_byte;
    logic [7:0]               mask_byte;

    always_comb begin
        changed = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            changed[p] = (score_i[4*p +: 4] != score_q[4*p +: 4]);
        end
    end

    assign w1c          = (wr && offset == REG_IRQ && wbs_sel_i[0]) ? wbs_dat_i[NUM_PLAYERS-1:0] : '0;
    assign pending_byte = 8'(pending);
    assign mask_byte    = 8'(irq_mask);

    // A fresh score change outranks a same-cycle clear so no event is ever lost.
    always_ff @(posedge wb_clk_i) begin
        score_q <= score_i;
        if (wb_rst_i) begin
            pending  <= '0;
            irq_mask <= '0;
            irq_o    <= 1'b0;
        end else begin
            pending <= (pending & ~w1c) | changed;
            if (wr && offset == REG_IRQ && wbs_sel_i[1]) begin
                irq_mask <= wbs_dat_i[8 +: NUM_PLAYERS];
            end
            irq_o <= |(pending & irq_mask);
        end
    end
`else
    assign irq_o = 1'b0;
`endif

    always_comb begin
        rd_data = '0;
        case (offset)
            REG_CTRL: begin
                rd_data[CTRL_SOFT_RST]         = soft_reset;
                rd_data[CTRL_DIFF_OVR]         = diff_override;
                rd_data[CTRL_DIFF_LSB +: 4]    = diff_val;
            end
            REG_CLKDIV: rd_data = 32'(clkdiv);
            REG_SCORE:  rd_data = 32'(score_i);
`ifdef PONG_WB_IRQ_EN
            REG_IRQ:    rd_data = {16'h0000, mask_byte, pending_byte};
`endif
            default:    rd_data = '0;
        endcase
    end

    // Writes land on the same edge that raises ack, so the ack cycle already shows the new value.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wbs_ack_o     <= 1'b0;
            wbs_dat_o     <= '0;
            soft_reset    <= 1'b0;
            diff_override <= 1'b0;
            diff_val      <= 4'h0;
            clkdiv        <= DIV_WIDTH'(DEFAULT_DIV);
            game_rst_o    <= 1'b1;
        end else begin
            wbs_ack_o  <= req;
            wbs_dat_o  <= (req && !wbs_we_i) ? rd_data : '0;
            game_rst_o <= la_rst_i | soft_reset;
            if (wr && offset == REG_CTRL && wbs_sel_i[0]) begin
                soft_reset    <= wbs_dat_i[CTRL_SOFT_RST];
                diff_override <= wbs_dat_i[CTRL_DIFF_OVR];
                diff_val      <= wbs_dat_i[CTRL_DIFF_LSB +: 4];
            end
            if (wr && offset == REG_CLKDIV) begin
                clkdiv <= clkdiv_wr_val;
            end
        end
    end

    clk_en_divider #(
        .DIV_WIDTH(DIV_WIDTH)
    ) u_divider (
        .clk  (wb_clk_i),
        .rst  (wb_rst_i | game_rst_o),
        .div  (clkdiv),
        .load (div_load),
        .ce   (game_ce_o)
    );

endmodule

// File: tb/tb_pong_wb_ctrl.sv
// Scoreboard bench for pong_wb_ctrl: bus reads are queued with expected data and checked on ack.
module tb_pong_wb_ctrl;
    import pong_pkg::*;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        wbRst;
    logic        wbsStb;
    logic        wbsCyc;
    logic        wbsWe;
    logic [3:0]  wbsSel;
    logic [31:0] wbsDatIn;
    logic [31:0] wbsAdr;
    logic        wbsAck;
    logic [31:0] wbsDatOut;
    logic        laRst;
    logic [3:0]  padDifficulty;
    logic [7:0]  score;
    logic        gameRst;
    logic [3:0]  difficulty;
    logic        gameCe;
    logic        irq;

    always #5 clk = ~clk;

    pong_wb_ctrl dut (
        .wb_clk_i        (clk),
        .wb_rst_i        (wbRst),
        .wbs_stb_i       (wbsStb),
        .wbs_cyc_i       (wbsCyc),
        .wbs_we_i        (wbsWe),
        .wbs_sel_i       (wbsSel),
        .wbs_dat_i       (wbsDatIn),
        .wbs_adr_i       (wbsAdr),
        .wbs_ack_o       (wbsAck),
        .wbs_dat_o       (wbsDatOut),
        .la_rst_i        (laRst),
        .pad_difficulty_i(padDifficulty),
        .score_i         (score),
        .game_rst_o      (gameRst),
        .difficulty_o    (difficulty),
        .game_ce_o       (gameCe),
        .irq_o           (irq)
    );

    typedef struct {
        bit          isRead;
        logic [31:0] data;
        string       name;
    } expT;

    expT expQ[$];
    expT monEntry;
    int  testsRun = 0;
    int  testsFailed = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Every ack must match the oldest queued request; read data is compared here.
    always @(negedge clk) begin
        if (wbsAck === 1'b1) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_ack", 32'd1, 32'd0);
            end else begin
                monEntry = expQ.pop_front();
                if (monEntry.isRead) checkOutput(monEntry.name, wbsDatOut, monEntry.data);
            end
        end
    end

    // Caller must be just after a rising edge; returns just after the edge that raised ack.
    task automatic applyStimulus(input logic [31:0] adr, input bit we, input logic [31:0] dat,
                                 input logic [3:0] sel, input bit expectAck,
                                 input logic [31:0] expData, input string name);
        expT e;
        int  waited;
        bit  gotAck;
        if (expectAck) begin
            e.isRead = !we;
            e.data   = expData;
            e.name   = name;
            expQ.push_back(e);
        end
        wbsAdr   = adr;
        wbsWe    = we;
        wbsDatIn = dat;
        wbsSel   = sel;
        wbsStb   = 1'b1;
        wbsCyc   = 1'b1;
        gotAck   = 1'b0;
        waited   = 0;
        while (!gotAck && waited < 8) begin
            @(posedge clk);
            #1;
            waited++;
            if (wbsAck === 1'b1) gotAck = 1'b1;
        end
        wbsStb = 1'b0;
        wbsCyc = 1'b0;
        wbsWe  = 1'b0;
        if (expectAck && !gotAck) begin
            checkOutput({name, "_ack_timeout"}, 32'd0, 32'd1);
            void'(expQ.pop_back());
        end
        if (!expectAck) checkOutput({name, "_no_ack"}, 32'(gotAck), 32'd0);
    endtask

    task automatic countCe(input int cycles, output int pulses);
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (gameCe) pulses++;
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [8:0] cePattern;
        logic [5:0] resumePattern;
        int         pulses;
        int         ackCount;

        wbRst = 1'b1; wbsStb = 1'b0; wbsCyc = 1'b0; wbsWe = 1'b0; wbsSel = 4'h0;
        wbsDatIn = '0; wbsAdr = '0; laRst = 1'b0; padDifficulty = 4'hA; score = 8'h00;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_ack", 32'(wbsAck), 32'd0);
        checkOutput("reset_dat", wbsDatOut, 32'd0);
        checkOutput("reset_game_rst", 32'(gameRst), 32'd1);
        checkOutput("reset_ce", 32'(gameCe), 32'd0);
        checkOutput("reset_irq", 32'(irq), 32'd0);

        @(posedge clk); #1;
        wbRst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            cePattern[i] = gameCe;
        end
        checkOutput("ce_after_reset_pattern", 32'(cePattern), 32'(9'b100100100));

        @(posedge clk); #1;
        applyStimulus(BASE + 32'h04, 1'b0, 32'h0, 4'hF, 1'b1, 32'h2, "clkdiv_reset_read");
        applyStimulus(BASE + 32'h04, 1'b1, 32'h7, 4'b0010, 1'b1, 32'h0, "clkdiv_lane1_write");
        applyStimulus(BASE + 32'h04, 1'b0, 32'h0, 4'hF, 1'b1, 32'h2, "clkdiv_lane1_unchanged");

        applyStimulus(BASE + 32'h00, 1'b1, 32'h52, 4'b0001, 1'b1, 32'h0, "ctrl_write_52");
        checkOutput("difficulty_override", 32'(difficulty), 32'h5);
        padDifficulty = 4'h3;
        #1;
        checkOutput("difficulty_ignores_pad", 32'(difficulty), 32'h5);
        applyStimulus(BASE + 32'h00, 1'b0, 32'h0, 4'hF, 1'b1, 32'h52, "ctrl_read_52");
        padDifficulty = 4'hA;
        applyStimulus(BASE + 32'h00, 1'b1, 32'h00, 4'b0001, 1'b1, 32'h0, "ctrl_write_00");
        checkOutput("difficulty_follows_pad", 32'(difficulty), 32'hA);

        applyStimulus(BASE + 32'h00, 1'b1, 32'h01, 4'b0001, 1'b1, 32'h0, "ctrl_soft_reset");
        @(negedge clk);
        checkOutput("soft_rst_ack_cycle", 32'(gameRst), 32'd0);
        @(negedge clk);
        checkOutput("soft_rst_after_ack", 32'(gameRst), 32'd1);
        countCe(6, pulses);
        checkOutput("soft_rst_ce_stopped", 32'(pulses), 32'd0);
        @(posedge clk); #1;
        applyStimulus(BASE + 32'h00, 1'b1, 32'h00, 4'b0001, 1'b1, 32'h0, "ctrl_soft_release");
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            resumePattern[i] = gameCe;
        end
        checkOutput("ce_resume_pattern", 32'(resumePattern), 32'(6'b001000));

        @(posedge clk); #1;
        laRst = 1'b1;
        @(negedge clk);
        checkOutput("la_rst_latency", 32'(gameRst), 32'd0);
        @(negedge clk);
        checkOutput("la_rst_asserted", 32'(gameRst), 32'd1);
        @(posedge clk); #1;
        laRst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("la_rst_released", 32'(gameRst), 32'd0);

        @(posedge clk); #1;
        applyStimulus(BASE + 32'h04, 1'b1, 32'h0, 4'hF, 1'b1, 32'h0, "clkdiv_write_0");
        countCe(10, pulses);
        checkOutput("clkdiv0_ce_every_cycle", 32'(pulses), 32'd10);
        @(posedge clk); #1;
        applyStimulus(BASE + 32'h04, 1'b1, 32'h2, 4'hF, 1'b1, 32'h0, "clkdiv_write_2");
        countCe(9, pulses);
        checkOutput("clkdiv2_ce_count", 32'(pulses), 32'd3);

        @(posedge clk); #1;
        score = 8'h93;
        applyStimulus(BASE + 32'h08, 1'b0, 32'h0, 4'hF, 1'b1, 32'h93, "score_read");
        applyStimulus(BASE + 32'h08, 1'b1, 32'hFFFF, 4'hF, 1'b1, 32'h0, "score_write_ignored");
        applyStimulus(BASE + 32'h08, 1'b0, 32'h0, 4'hF, 1'b1, 32'h93, "score_read_after_write");
        applyStimulus(BASE + 32'h10, 1'b1, 32'hDEAD, 4'hF, 1'b1, 32'h0, "unmapped_write");
        applyStimulus(BASE + 32'h10, 1'b0, 32'h0, 4'hF, 1'b1, 32'h0, "unmapped_read");
        applyStimulus(BASE + 32'hFC, 1'b0, 32'h0, 4'hF, 1'b1, 32'h0, "top_of_window_read");

`ifdef PONG_WB_IRQ_EN
        applyStimulus(BASE + 32'h0C, 1'b1, 32'h1FF, 4'b0011, 1'b1, 32'h0, "irq_mask_and_clear");
        applyStimulus(BASE + 32'h0C, 1'b0, 32'h0, 4'hF, 1'b1, 32'h100, "irq_read_masked_clear");
        score = 8'h94;
        @(negedge clk);
        checkOutput("irq_change_cycle", 32'(irq), 32'd0);
        @(negedge clk);
        checkOutput("irq_one_cycle_later", 32'(irq), 32'd0);
        @(negedge clk);
        checkOutput("irq_two_cycles_later", 32'(irq), 32'd1);
        @(posedge clk); #1;
        applyStimulus(BASE + 32'h0C, 1'b0, 32'h0, 4'hF, 1'b1, 32'h101, "irq_read_pending");
        score = 8'h95;
        applyStimulus(BASE + 32'h0C, 1'b1, 32'h1, 4'b0001, 1'b1, 32'h0, "irq_w1c_with_change");
        applyStimulus(BASE + 32'h0C, 1'b0, 32'h0, 4'hF, 1'b1, 32'h101, "irq_set_wins");
        applyStimulus(BASE + 32'h0C, 1'b1, 32'h1, 4'b0001, 1'b1, 32'h0, "irq_w1c");
        applyStimulus(BASE + 32'h0C, 1'b0, 32'h0, 4'hF, 1'b1, 32'h100, "irq_read_cleared");
        @(negedge clk);
        checkOutput("irq_deasserted", 32'(irq), 32'd0);
        @(posedge clk); #1;
        score = 8'hA5;
        @(posedge clk); #1;
        applyStimulus(BASE + 32'h0C, 1'b0, 32'h0, 4'hF, 1'b1, 32'h102, "irq_player1_pending");
        @(negedge clk);
        checkOutput("irq_masked_player1", 32'(irq), 32'd0);
        @(posedge clk); #1;
`else
        applyStimulus(BASE + 32'h0C, 1'b1, 32'h1FF, 4'b0011, 1'b1, 32'h0, "irq_write_dropped");
        applyStimulus(BASE + 32'h0C, 1'b0, 32'h0, 4'hF, 1'b1, 32'h0, "irq_reads_zero");
        score = 8'h94;
        repeat (3) @(negedge clk);
        checkOutput("irq_tied_low", 32'(irq), 32'd0);
        @(posedge clk); #1;
`endif

        applyStimulus(BASE + 32'h100, 1'b0, 32'h0, 4'hF, 1'b0, 32'h0, "out_of_window");

        applyStimulus(BASE + 32'h04, 1'b1, 32'h5, 4'hF, 1'b1, 32'h0, "clkdiv_write_5");
        applyStimulus(BASE + 32'h00, 1'b1, 32'h52, 4'b0001, 1'b1, 32'h0, "ctrl_write_52_again");
        wbsAdr = BASE + 32'h04; wbsWe = 1'b0; wbsSel = 4'hF;
        wbsStb = 1'b1; wbsCyc = 1'b1; wbRst = 1'b1;
        @(posedge clk); #1;
        wbsStb = 1'b0; wbsCyc = 1'b0; wbRst = 1'b0;
        ackCount = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (wbsAck) ackCount++;
        end
        checkOutput("reset_mid_transaction_no_ack", 32'(ackCount), 32'd0);
        checkOutput("difficulty_after_reset", 32'(difficulty), 32'hA);
        @(posedge clk); #1;
        applyStimulus(BASE + 32'h04, 1'b0, 32'h0, 4'hF, 1'b1, 32'h2, "clkdiv_after_reset");
        applyStimulus(BASE + 32'h00, 1'b0, 32'h0, 4'hF, 1'b1, 32'h0, "ctrl_after_reset");

        repeat (4) @(posedge clk);
        checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
